tone_sequencer: RTL and testbench



---
 rtl/tone_seq_pkg.sv | 26 ++
 rtl/tone_tick_gen.sv | 31 +++
 rtl/tone_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and constants for the tone sequencer: FSM state encoding,
// note-table entry layout and default timing constants.
package tone_seq_pkg;

   localparam int DEFAULT_TICK_DIV = 50000;
   localparam int DEFAULT_DUR_W    = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PLAY,
      GAP,
      FIN
   } state_e;

   typedef struct packed {
      logic [31:0]              freq;
      logic [DEFAULT_DUR_W-1:0] dur;
   } note_t;

   // A counter for a divide-by-1 still needs one bit of storage.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/tone_tick_gen.sv
// Free-running prescaler with synchronous clear; tick_o is high for one
// cycle out of every TICK_DIV, the first one TICK_DIV-1 cycles after a clear.
module tone_tick_gen
   import tone_seq_pkg::*;
#(
   parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            PW   = clog2_min1(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + PW'(1);
      if (clr_i || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Note-table player driving the buzzer frequency divider (half-period + run).
// Optional looping playback is enabled by defining TONE_SEQ_LOOP_EN.
//
// state | meaning
// IDLE  | waiting for start; note_idx holds last value
// FETCH | latch table[note_idx] into holding regs; dur=0 skips the entry
// PLAY  | divider runs (unless rest) for dur ticks
// GAP   | divider stopped for GAP_TICKS ticks after each note
// FIN   | one-cycle done pulse, then IDLE
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int DUR_W     = DEFAULT_DUR_W,
   parameter int TICK_DIV  = DEFAULT_TICK_DIV,
   parameter int GAP_TICKS = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_freq,
   input  logic [DUR_W-1:0]  wr_dur,
   input  logic [ADDR_W:0]   seq_len,
   input  logic              start,
   input  logic              stop,
`ifdef TONE_SEQ_LOOP_EN
   input  logic              loop,
`endif
   output logic [31:0]       freq_out,
   output logic              div_run,
   output logic [ADDR_W-1:0] note_idx,
   output logic              busy,
   output logic              done
);

   note_t             note_tbl_q [DEPTH];
   note_t             entry;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [31:0]       freq_q, freq_d;
   logic [DUR_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic              loop_q, loop_d, loop_in;
   logic              adv, tick, tick_clr;

`ifdef TONE_SEQ_LOOP_EN
   assign loop_in = loop;
`else
   assign loop_in = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) note_tbl_q[wr_addr] <= '{freq: wr_freq, dur: DEFAULT_DUR_W'(wr_dur)};
   end

   assign entry = note_tbl_q[idx_q];

   tone_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   // Prescaler restarts whenever a timed state is entered, so each PLAY/GAP
   // lasts an exact multiple of TICK_DIV cycles.
   assign tick_clr = ((state_q != PLAY) && (state_q != GAP)) || (state_d != state_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      len_d      = len_q;
      freq_d     = freq_q;
      tick_cnt_d = tick_cnt_q;
      loop_d     = loop_q;
      adv        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               len_d   = seq_len;
               idx_d   = '0;
               loop_d  = loop_in;
               state_d = (seq_len != '0) ? FETCH : FIN;
            end
         end
         FETCH: begin
            freq_d     = entry.freq;
            tick_cnt_d = DUR_W'(entry.dur);
            if (entry.dur == '0) adv = 1'b1;
            else                 state_d = PLAY;
         end
         PLAY: begin
            if (tick) begin
               if (tick_cnt_q > DUR_W'(1)) begin
                  tick_cnt_d = tick_cnt_q - DUR_W'(1);
               end else if (GAP_TICKS > 0) begin
                  tick_cnt_d = DUR_W'(GAP_TICKS);
                  state_d    = GAP;
               end else begin
                  tick_cnt_d = '0;
                  adv        = 1'b1;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (tick_cnt_q > DUR_W'(1)) begin
                  tick_cnt_d = tick_cnt_q - DUR_W'(1);
               end else begin
                  tick_cnt_d = '0;
                  adv        = 1'b1;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (adv) begin
         if ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1))) begin
            if (loop_q) begin
               idx_d   = '0;
               state_d = FETCH;
            end else begin
               state_d = FIN;
            end
         end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
         end
      end

      // Abort wins over start and over any same-cycle advance.
      if (stop) begin
         state_d = IDLE;
         idx_d   = idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         freq_q     <= '0;
         tick_cnt_q <= '0;
         loop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         freq_q     <= freq_d;
         tick_cnt_q <= tick_cnt_d;
         loop_q     <= loop_d;
      end
   end

   assign freq_out = freq_q;
   assign div_run  = (state_q == PLAY) && (freq_q != '0);
   assign note_idx = idx_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4, GAP_TICKS=1: cycle
// segments of expected outputs plus hand-written reset/loop sequences.
module tb_tone_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_freq = '0;
   logic [15:0] wr_dur = '0;
   logic [4:0]  seq_len = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop = 1'b0;
   logic [31:0] freq_out;
   logic        div_run;
   logic [3:0]  note_idx;
   logic        busy;
   logic        done;

   int vectors = 0;
   int miscompares = 0;

   tone_sequencer #(
      .DEPTH(16), .ADDR_W(4), .DUR_W(16), .TICK_DIV(4), .GAP_TICKS(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_freq  (wr_freq),
      .wr_dur   (wr_dur),
      .seq_len  (seq_len),
      .start    (start),
      .stop     (stop),
`ifdef TONE_SEQ_LOOP_EN
      .loop     (loop),
`endif
      .freq_out (freq_out),
      .div_run  (div_run),
      .note_idx (note_idx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      int          n;
      logic        st;
      logic        sp;
      logic [4:0]  len;
      logic        run;
      logic [31:0] fr;
      logic        cf;
      logic [3:0]  idx;
      logic        bsy;
      logic        dn;
   } seg_t;

   seg_t segs[$];

   function automatic void add(string nm, int n, logic st, logic sp, logic [4:0] len,
                               logic run, logic [31:0] fr, logic cf, logic [3:0] idx,
                               logic bsy, logic dn);
      seg_t s;
      s.nm = nm; s.n = n; s.st = st; s.sp = sp; s.len = len;
      s.run = run; s.fr = fr; s.cf = cf; s.idx = idx; s.bsy = bsy; s.dn = dn;
      segs.push_back(s);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic e_run, logic [31:0] e_fr, logic e_cf,
                      logic [3:0] e_idx, logic e_bsy, logic e_dn);
      vectors++;
      if (div_run !== e_run || busy !== e_bsy || done !== e_dn || note_idx !== e_idx ||
          (e_cf && freq_out !== e_fr)) begin
         miscompares++;
         $display("FAIL %s @%0t: got run=%b freq=%0d idx=%0d busy=%b done=%b, want run=%b freq=%0d%s idx=%0d busy=%b done=%b",
                  nm, $time, div_run, freq_out, note_idx, busy, done,
                  e_run, e_fr, e_cf ? "" : "(x)", e_idx, e_bsy, e_dn);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] f, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_freq = f; wr_dur = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic run_segs();
      foreach (segs[k]) begin
         for (int i = 0; i < segs[k].n; i++) begin
            start = segs[k].st; stop = segs[k].sp; seq_len = segs[k].len;
            step();
            start = 1'b0; stop = 1'b0;
            chk($sformatf("%s[%0d]", segs[k].nm, i), segs[k].run, segs[k].fr, segs[k].cf,
                segs[k].idx, segs[k].bsy, segs[k].dn);
         end
      end
      segs.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[$];
      logic saw_done;

      step(); step();
      chk("reset", 0, 0, 1, 0, 0, 0);
      rst = 1'b0;

      // Basic play: {1000,2},{500,1}
      wr(0, 1000, 2); wr(1, 500, 1);
      add("t1_start", 1, 1, 0, 2, 0, 0,    0, 0, 1, 0);
      add("t1_play0", 8, 0, 0, 2, 1, 1000, 1, 0, 1, 0);
      add("t1_gap0",  4, 0, 0, 2, 0, 1000, 1, 0, 1, 0);
      add("t1_fetch1",1, 0, 0, 2, 0, 1000, 1, 1, 1, 0);
      add("t1_play1", 4, 0, 0, 2, 1, 500,  1, 1, 1, 0);
      add("t1_gap1",  4, 0, 0, 2, 0, 500,  1, 1, 1, 0);
      add("t1_fin",   1, 0, 0, 2, 0, 500,  1, 1, 1, 1);
      add("t1_idle",  2, 0, 0, 2, 0, 500,  1, 1, 0, 0);
      run_segs();

      // Rest and skip: {0,2},{700,0},{300,1}
      wr(0, 0, 2); wr(1, 700, 0); wr(2, 300, 1);
      add("t2_start", 1, 1, 0, 3, 0, 0,   0, 0, 1, 0);
      add("t2_rest",  8, 0, 0, 3, 0, 0,   1, 0, 1, 0);
      add("t2_gap0",  4, 0, 0, 3, 0, 0,   1, 0, 1, 0);
      add("t2_fetch1",1, 0, 0, 3, 0, 0,   1, 1, 1, 0);
      add("t2_fetch2",1, 0, 0, 3, 0, 700, 1, 2, 1, 0);
      add("t2_play2", 4, 0, 0, 3, 1, 300, 1, 2, 1, 0);
      add("t2_gap2",  4, 0, 0, 3, 0, 300, 1, 2, 1, 0);
      add("t2_fin",   1, 0, 0, 3, 0, 300, 1, 2, 1, 1);
      add("t2_idle",  2, 0, 0, 3, 0, 300, 1, 2, 0, 0);
      run_segs();

      // Stop during PLAY of note 0
      wr(0, 1000, 2);
      add("t3_start", 1, 1, 0, 1, 0, 0,    0, 0, 1, 0);
      add("t3_play",  3, 0, 0, 1, 1, 1000, 1, 0, 1, 0);
      add("t3_stop",  1, 0, 1, 1, 0, 1000, 1, 0, 0, 0);
      add("t3_idle",  6, 0, 0, 1, 0, 1000, 1, 0, 0, 0);
      // Zero-length start
      add("t4_len0",  1, 1, 0, 0, 0, 0,    0, 0, 1, 1);
      add("t4_idle",  3, 0, 0, 0, 0, 0,    0, 0, 0, 0);
      // Start while busy is ignored
      add("t4_start", 1, 1, 0, 1, 0, 0,    0, 0, 1, 0);
      add("t4_play",  5, 0, 0, 1, 1, 1000, 1, 0, 1, 0);
      add("t4_rest",  1, 1, 0, 2, 1, 1000, 1, 0, 1, 0);
      add("t4_play2", 2, 0, 0, 2, 1, 1000, 1, 0, 1, 0);
      add("t4_gap",   4, 0, 0, 2, 0, 1000, 1, 0, 1, 0);
      add("t4_fin",   1, 0, 0, 2, 0, 1000, 1, 0, 1, 1);
      add("t4_idle",  2, 0, 0, 2, 0, 1000, 1, 0, 0, 0);
      run_segs();

      // Reset mid-GAP of note 1, then replay from entry 0
      wr(0, 1000, 1); wr(1, 500, 1);
      seq_len = 2; start = 1'b1; step(); start = 1'b0;
      chk("t5_fetch", 0, 0, 0, 0, 1, 0);
      repeat (15) step();
      chk("t5_gap1", 0, 500, 1, 1, 1, 0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t5_rst", 0, 0, 1, 0, 0, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("t5_refetch", 0, 0, 1, 0, 1, 0);
      step();
      chk("t5_replay", 1, 1000, 1, 0, 1, 0);
      // Rewriting the entry being played must not disturb freq_out
      wr(0, 2000, 1);
      chk("t5_wr_hold", 1, 1000, 1, 0, 1, 0);
      stop = 1'b1; step(); stop = 1'b0;
      chk("t5_stop", 0, 1000, 1, 0, 0, 0);

`ifdef TONE_SEQ_LOOP_EN
      // Looping playback over entries {2000,1},{500,1}
      loop = 1'b1; seq_len = 2; start = 1'b1; step(); start = 1'b0; loop = 1'b0;
      saw_done = 1'b0;
      seq.push_back(int'(note_idx));
      for (int c = 0; c < 80 && seq.size() < 4; c++) begin
         step();
         if (done) saw_done = 1'b1;
         if (int'(note_idx) != seq[$]) seq.push_back(int'(note_idx));
      end
      vectors++;
      if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
         miscompares++;
         $display("FAIL t6_idx_seq: got %p, want '{0,1,0,1}", seq);
      end
      vectors++;
      if (saw_done) begin
         miscompares++;
         $display("FAIL t6_no_done: got done=1 during loop, want done=0");
      end
      stop = 1'b1; step(); stop = 1'b0;
      chk("t6_stop", 0, 0, 0, 1, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
